gold_code_gen: RTL and testbench
================================

Name: gold_code_gen

Overview:
Parametrised Gold-code chip generator and successor to the fixed 6-bit dual m-sequence pair. It contains two N-bit Fibonacci LFSRs (A, B) with programmable taps and runtime seeds, and a runtime phase offset applied to B before output starts. It adds a start/stop handshake, chip-enable pacing, a chip index and a period epoch strobe. It sits between the spreading-code control logic and the modulator/correlator datapath.

Parameters:
N, 6, LFSR length in bits (3..16); code period L = 2^N - 1
POLY_A, 6'b000011 (N bits), tap mask for LFSR A; bit i set means stage i feeds back
POLY_B, 6'b100111 (N bits), tap mask for LFSR B

Ports:
clkin  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request to begin a sequence; sampled only in IDLE
stop  in  1  return to IDLE; sampled in ALIGN and RUN
seed_a  in  N  initial state of LFSR A, captured on accepted start
seed_b  in  N  initial state of LFSR B, captured on accepted start
shift_b  in  N  phase offset in chips applied to LFSR B, captured on accepted start
chip_en  in  1  advance one chip in RUN
busy  out  1  high in LOAD, ALIGN and RUN
valid  out  1  high in RUN; code_gold is meaningful
code_gold  out  1  current Gold chip = A[0] ^ B[0]
chip_idx  out  N  index of the current chip, 0..L-1
epoch  out  1  one-cycle pulse when the chip at index L-1 is consumed

Behaviour:
- Reset (async, any state): state=IDLE; LFSR A and B, counters and all outputs = 0.
- LFSR step: fb = ^(s & POLY); s_next = {fb, s[N-1:1]}; output bit = s[0].
- Zero-seed guard: a captured seed of 0 is replaced by 1 (all-zero lock-up is illegal).
- shift_b == L (all ones) is treated as 0.
- FSM:
  - IDLE: busy=0, valid=0. start=1 captures seeds and shift, then goes to LOAD. stop is ignored.
  - LOAD (1 cycle): A and B loaded, chip_idx=0, offset counter=shift_b. Next state is RUN if the counter is 0, else ALIGN.
  - ALIGN: B steps every cycle and A holds; the counter decrements. On the cycle the counter goes 1->0, next state is RUN. ALIGN lasts exactly shift_b cycles. chip_en is ignored.
  - RUN: valid=1. code_gold = A[0]^B[0] from the current registers (no added latency). On chip_en=1, A and B both step and chip_idx increments. If chip_idx==L-1, chip_idx wraps to 0 and epoch=1 for that cycle. With chip_en=0, everything holds and epoch=0.
- Latency: start accepted at cycle T gives valid=1 at T+2+shift_b.
- stop has priority over chip_en in the same cycle: no advance, no epoch, next state IDLE. LFSR contents are retained but are not valid.
- start while busy is ignored; stop and start in the same IDLE cycle means start is accepted.
- After L chip_en steps, A and B return to their post-ALIGN states. The sequence is periodic with period L with no re-alignment.
- code_gold, valid, busy, chip_idx and epoch are registered or derived from registers only; no input-to-output combinational path.

Optional Feature:
Macro GOLD_BIPOLAR_EN.
- Defined: adds output port chip_bip [1:0] (signed). It is +1 (2'b01) when code_gold=0 and -1 (2'b11) when code_gold=1 while valid=1, and 2'b00 when valid=0. The reset value is 2'b00.
- Not defined: the port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
- Reset and idle: assert rst mid-RUN -> next sample has busy=0, valid=0, code_gold=0, chip_idx=0, epoch=0. Hold rst low with no start -> outputs stay 0.
- Zero-offset run: seed_a=6'b101010, seed_b=6'b101010, shift_b=0, start, chip_en=1 continuous -> valid rises 2 cycles after start. 63 chips match a golden model of A^B. epoch pulses at exactly every 63rd chip_en, and chip_idx wraps 62->0.
- Offset alignment: shift_b=5 -> valid rises at start+7. The first chip equals model A(0)^B(5), and chips 0..62 equal the shift_b=0 run with B rotated by 5.
- Pacing/stop: chip_en toggled 1,0,0,1 -> chip_idx advances only on enabled cycles and code_gold holds otherwise. stop with chip_en=1 -> no epoch/advance, IDLE next cycle, and a new start is accepted.
- Boundaries: seed_a=0 -> behaves as seed_a=1. shift_b=6'b111111 -> identical to shift_b=0, ALIGN skipped. start asserted during RUN -> ignored.
- GOLD_BIPOLAR_EN build: chip_bip=2'b01 for every code_gold=0 chip and 2'b11 for every code_gold=1 chip, and 2'b00 in IDLE/ALIGN.

Source files
------------

// File: rtl/gold_code_if.sv
// Control/status bundle for gold_code_gen.
// Macro GOLD_BIPOLAR_EN adds the signed bipolar chip output.
interface gold_code_if #(
    parameter int unsigned N = 6
);
    logic         start;
    logic         stop;
    logic [N-1:0] seed_a;
    logic [N-1:0] seed_b;
    logic [N-1:0] shift_b;
    logic         chip_en;
    logic         busy;
    logic         valid;
    logic         code_gold;
    logic [N-1:0] chip_idx;
    logic         epoch;
`ifdef GOLD_BIPOLAR_EN
    logic signed [1:0] chip_bip;
`endif

    modport master (
        output start, stop, seed_a, seed_b, shift_b, chip_en,
        input  busy, valid, code_gold, chip_idx, epoch
`ifdef GOLD_BIPOLAR_EN
        , input chip_bip
`endif
    );

    modport slave (
        input  start, stop, seed_a, seed_b, shift_b, chip_en,
        output busy, valid, code_gold, chip_idx, epoch
`ifdef GOLD_BIPOLAR_EN
        , output chip_bip
`endif
    );
endinterface

// File: rtl/gold_code_gen.sv
// Gold-code chip generator: two Fibonacci LFSRs with a runtime phase offset on B.
// Macro GOLD_BIPOLAR_EN adds the chip_bip (+1/-1) output.
module gold_code_gen #(
    parameter int unsigned    N      = 6,
    parameter logic [N-1:0]   POLY_A = N'(6'b000011),
    parameter logic [N-1:0]   POLY_B = N'(6'b100111)
) (
    input  logic      clkin,
    input  logic      rst,
    gold_code_if.slave bus
);
    localparam logic [N-1:0] LMax = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StAlign, StRun} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [N-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic         epoch_q, epoch_d;
    logic         busy_q, valid_q;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s, input logic [N-1:0] poly);
        return {^(s & poly), s[N-1:1]};
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        epoch_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // All-zero state would lock the LFSR; an all-ones offset is a full period.
                    a_d     = (bus.seed_a == '0) ? N'(1) : bus.seed_a;
                    b_d     = (bus.seed_b == '0) ? N'(1) : bus.seed_b;
                    cnt_d   = (bus.shift_b == LMax) ? '0 : bus.shift_b;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = (cnt_q == '0) ? StRun : StAlign;
            end
            StAlign: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else begin
                    b_d   = lfsr_step(b_q, POLY_B);
                    cnt_d = cnt_q - N'(1);
                    if (cnt_q == N'(1)) state_d = StRun;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (bus.chip_en) begin
                    a_d = lfsr_step(a_q, POLY_A);
                    b_d = lfsr_step(b_q, POLY_B);
                    if (idx_q == LMax - N'(1)) begin
                        idx_d   = '0;
                        epoch_d = 1'b1;
                    end else begin
                        idx_d = idx_q + N'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            epoch_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            busy_q  <= (state_d != StIdle);
            valid_q <= (state_d == StRun);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    // Gated so stale LFSR contents after stop never appear as a chip.
    assign bus.code_gold = valid_q & (a_q[0] ^ b_q[0]);
    assign bus.chip_idx  = idx_q;
    assign bus.epoch     = epoch_q;

`ifdef GOLD_BIPOLAR_EN
    assign bus.chip_bip = !valid_q ? 2'sb00 : ((a_q[0] ^ b_q[0]) ? 2'sb11 : 2'sb01);
`endif
endmodule

// File: tb/tb_gold_code_gen.sv
// Scoreboard bench for gold_code_gen: driver pushes expected chips, monitor pops on valid.
module tb_gold_code_gen;
    localparam int N = 6;
    localparam int L = 63;
    localparam logic [N-1:0] PA = 6'b000011;
    localparam logic [N-1:0] PB = 6'b100111;
    localparam int SeqLen = 320;

    typedef struct {
        bit code;
        int idx;
        bit ep;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    exp_t exp_q[$];
    bit   seq_a[SeqLen];
    bit   seq_b[SeqLen];

    gold_code_if #(.N(N)) bus ();

    gold_code_gen #(.N(N), .POLY_A(PA), .POLY_B(PB)) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Output bit stream of an LFSR: bit i is stage 0 after i steps.
    task automatic build(input logic [N-1:0] seed, input logic [N-1:0] poly, input bit is_b);
        logic [N-1:0] s;
        s = seed;
        for (int i = 0; i < SeqLen; i++) begin
            if (is_b) seq_b[i] = s[0];
            else      seq_a[i] = s[0];
            s = {^(s & poly), s[N-1:1]};
        end
    endtask

    function automatic int idle_word();
        return {bus.busy, bus.valid, bus.code_gold, bus.epoch, 2'b00, bus.chip_idx};
    endfunction

    // mode: 0 continuous, 1 random enable with stray starts, 2 pattern 1,0,0,1
    task automatic run(input logic [N-1:0] sa, input logic [N-1:0] sb, input logic [N-1:0] sh,
                       input int n, input int mode, input bit do_stop, input bit stop_at_start);
        int s_eff, cyc, k;
        bit wrap, en, last;
        s_eff = (sh == 6'h3f) ? 0 : int'(sh);
        build((sa == 0) ? 6'd1 : sa, PA, 1'b0);
        build((sb == 0) ? 6'd1 : sb, PB, 1'b1);
        bus.seed_a = sa; bus.seed_b = sb; bus.shift_b = sh;
        bus.start = 1'b1; bus.stop = stop_at_start; bus.chip_en = 1'b0;
        @(posedge clk) #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.seed_a = 6'($urandom); bus.seed_b = 6'($urandom); bus.shift_b = 6'($urandom);
        chk("busy_after_start", int'(bus.busy), 1);
        cyc = 0;
        while (!bus.valid && cyc < 80) begin
            @(posedge clk) #1;
            cyc++;
        end
        chk("valid_latency", cyc + 1, 2 + s_eff);
        if (!bus.valid) return;
        k = 0;
        wrap = 1'b0;
        for (int c = 0; c < n; c++) begin
            last = do_stop && (c == n - 1);
            case (mode)
                1:       en = ($urandom_range(0, 2) != 0);
                2:       en = (c % 4 == 0) || (c % 4 == 3);
                default: en = 1'b1;
            endcase
            if (last) en = 1'b1;
            bus.chip_en = en;
            bus.stop    = last;
            bus.start   = (mode == 1) && !last && ($urandom_range(0, 7) == 0);
            exp_q.push_back('{code: seq_a[k] ^ seq_b[k + s_eff], idx: k % L, ep: wrap});
            @(posedge clk) #1;
            if (!last) begin
                if (en) begin
                    wrap = (k % L == L - 1);
                    k++;
                end else begin
                    wrap = 1'b0;
                end
            end
        end
        bus.chip_en = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
        if (do_stop) begin
            chk("stop_valid", int'(bus.valid), 0);
            chk("stop_busy", int'(bus.busy), 0);
            chk("stop_epoch", int'(bus.epoch), 0);
        end
    endtask

    // Monitor: compares every cycle in which the DUT presents a valid chip.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("code_gold", int'(bus.code_gold), int'(e.code));
                    chk("chip_idx", int'(bus.chip_idx), e.idx);
                    chk("epoch", int'(bus.epoch), int'(e.ep));
`ifdef GOLD_BIPOLAR_EN
                    chk("chip_bip", int'($unsigned(bus.chip_bip)), e.code ? 3 : 1);
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.chip_en = 1'b0;
        bus.seed_a = '0; bus.seed_b = '0; bus.shift_b = '0;
        #12;
        chk("reset_outputs", idle_word(), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #1;
            chk("idle_outputs", idle_word(), 0);
`ifdef GOLD_BIPOLAR_EN
            chk("idle_chip_bip", int'($unsigned(bus.chip_bip)), 0);
`endif
        end

        // Zero offset, three full periods, stop on the chip at index 62.
        run(6'b101010, 6'b101010, 6'd0, 189, 0, 1'b1, 1'b0);
        // Offset 5, started with stop also high in IDLE.
        run(6'b101010, 6'b101010, 6'd5, 70, 0, 1'b1, 1'b1);
        // Enable pattern 1,0,0,1.
        run(6'b000111, 6'b110001, 6'd2, 24, 2, 1'b1, 1'b0);
        // Zero seed A and all-ones offset.
        run(6'd0, 6'b011011, 6'h3f, 70, 0, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run(6'($urandom), 6'($urandom), 6'($urandom_range(0, 20)), 120, 1, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a run.
        run(6'b100001, 6'b010101, 6'd3, 30, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_reset", idle_word(), 0);
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk("post_reset_idle", idle_word(), 0);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
